// File: rtl/mips_run_pkg.sv
// Shared encodings for the mips run controller: FSM states and run modes.
package mips_run_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RST_HOLD  = 3'd1,
        RUN       = 3'd2,
        STEP_WAIT = 3'd3,
        STEP_EXEC = 3'd4,
        HALT      = 3'd5
    } run_state_e;

    localparam logic [1:0] MODE_FREE = 2'd0;
    localparam logic [1:0] MODE_STEP = 2'd1;
    localparam logic [1:0] MODE_BP   = 2'd2;

endpackage

// File: rtl/mips_run_ctrl_halt_detect.sv
// Halt detection: tracks the previous PC and a same-PC run length, and
// flags breakpoint, stall (self-loop) and cycle-budget timeout conditions.
// All flags are qualified by the core enable so they only fire on cycles
// the core actually executed.
module halt_detect
    import mips_run_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int CNT_W     = 32,
    parameter int STALL_CYC = 4,
    parameter int MAX_CYC   = 10000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic [PC_W-1:0]  bp_addr_i,
    input  logic [CNT_W-1:0] cnt_nxt_i,
    output logic             halt_bp_o,
    output logic             halt_stall_o,
    output logic             halt_to_o
);

    localparam int SW = (STALL_CYC > 2) ? $clog2(STALL_CYC) : 1;
    localparam logic [SW-1:0]    STALL_LIM = SW'(STALL_CYC - 2);
    localparam logic [CNT_W-1:0] MAX_C     = CNT_W'(MAX_CYC);

    logic [PC_W-1:0] prev_pc_q;
    logic [SW-1:0]   stall_q;
    logic            pc_same;

    assign pc_same = (pc_i == prev_pc_q);

    // PC history and same-PC run length; only advance on executed cycles
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_pc_q <= '0;
            stall_q   <= '0;
        end else if (clr_i) begin
            prev_pc_q <= '0;
            stall_q   <= '0;
        end else if (en_i) begin
            prev_pc_q <= pc_i;
            stall_q   <= pc_same ? stall_q + 1'b1 : '0;
        end
    end

    assign halt_bp_o    = en_i && (mode_i == MODE_BP) && (pc_i == bp_addr_i);
    // stall_q counts repeats already seen; this cycle's match makes STALL_CYC samples
    assign halt_stall_o = en_i && pc_same && (stall_q == STALL_LIM);
    assign halt_to_o    = en_i && (cnt_nxt_i == MAX_C);

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for the mips core: sequences core reset, gates execution
// via a clock enable in free-run / single-step / run-to-breakpoint modes,
// counts executed cycles and freezes the core when a halt is detected.
module mips_run_ctrl
    import mips_run_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int CNT_W     = 32,
    parameter int RST_CYC   = 2,
    parameter int STALL_CYC = 4,
    parameter int MAX_CYC   = 10000
) (
    input  logic             clk,
    input  logic             pc_rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             step_req,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    output logic             cpu_rst,
    output logic             cpu_en,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [2:0]       state,
    output logic             halted,
    output logic             timeout,
    output logic [PC_W-1:0]  halt_pc
);

    localparam int HW = $clog2(RST_CYC + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYC - 1);

    run_state_e      state_q;
    logic [HW-1:0]   hold_q;
    logic            step_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            halted_q, timeout_q;
    logic [PC_W-1:0] halt_pc_q;

    logic launch, en, step_rise;
    logic halt_bp, halt_stall, halt_to, pc_halt;

    assign en        = (state_q == RUN) || (state_q == STEP_EXEC);
    assign launch    = start && ((state_q == IDLE) || (state_q == HALT));
    assign step_rise = step_req && !step_q;
    assign cnt_d     = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign pc_halt   = halt_bp || halt_stall;

    halt_detect #(
        .PC_W(PC_W), .CNT_W(CNT_W), .STALL_CYC(STALL_CYC), .MAX_CYC(MAX_CYC)
    ) u_halt (
        .clk_i        (clk),
        .rst_i        (pc_rst),
        .clr_i        (launch),
        .en_i         (en),
        .mode_i       (mode),
        .pc_i         (pc),
        .bp_addr_i    (bp_addr),
        .cnt_nxt_i    (cnt_d),
        .halt_bp_o    (halt_bp),
        .halt_stall_o (halt_stall),
        .halt_to_o    (halt_to)
    );

    // Step request edge detector: a held request grants a single step
    always_ff @(posedge clk or posedge pc_rst) begin
        if (pc_rst) step_q <= 1'b0;
        else        step_q <= step_req;
    end

    // Run FSM with reset hold, cycle counter and halt capture
    always_ff @(posedge clk or posedge pc_rst) begin
        if (pc_rst) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            cnt_q     <= '0;
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
            halt_pc_q <= '0;
        end else begin
            if (en) cnt_q <= cnt_d;
            case (state_q)
                IDLE, HALT: begin
                    if (start) begin
                        state_q   <= RST_HOLD;
                        hold_q    <= '0;
                        cnt_q     <= '0;
                        halted_q  <= 1'b0;
                        timeout_q <= 1'b0;
                        halt_pc_q <= '0;
                    end
                end
                RST_HOLD: begin
                    hold_q <= hold_q + 1'b1;
                    if (hold_q == HOLD_LAST)
                        state_q <= (mode == MODE_STEP) ? STEP_WAIT : RUN;
                end
                STEP_WAIT: begin
                    if (step_rise) state_q <= STEP_EXEC;
                end
                RUN, STEP_EXEC: begin
                    if (pc_halt || halt_to) begin
                        state_q   <= HALT;
                        halt_pc_q <= pc;
                        halted_q  <= pc_halt;
                        timeout_q <= !pc_halt;
                    end else if (state_q == STEP_EXEC) begin
                        state_q <= STEP_WAIT;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_rst   = (state_q == IDLE) || (state_q == RST_HOLD);
    assign cpu_en    = en;
    assign cycle_cnt = cnt_q;
    assign state     = state_q;
    assign halted    = halted_q;
    assign timeout   = timeout_q;
    assign halt_pc   = halt_pc_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: a PC stimulus per scenario, a scoreboard of
// expected halt results pushed at launch and popped when HALT appears.
module tb_mips_run_ctrl;

    logic        clk = 1'b0;
    logic        pc_rst, start, step_req;
    logic [1:0]  mode;
    logic [31:0] bp_addr, pc;
    logic        cpu_rst, cpu_en, halted, timeout;
    logic [31:0] cycle_cnt, halt_pc;
    logic [2:0]  state;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        h;
        logic        t;
        logic [31:0] hpc;
        logic [31:0] cnt;
    } exp_t;
    exp_t sb[$];

    mips_run_ctrl dut (
        .clk(clk), .pc_rst(pc_rst), .start(start), .mode(mode),
        .step_req(step_req), .bp_addr(bp_addr), .pc(pc),
        .cpu_rst(cpu_rst), .cpu_en(cpu_en), .cycle_cnt(cycle_cnt),
        .state(state), .halted(halted), .timeout(timeout), .halt_pc(halt_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pc_of(input int kind, input int k);
        case (kind)
            0:       return (k < 8) ? 32'(4 * k) : 32'h20;
            3:       return (k == 0) ? 32'h4 : 32'h10;
            4:       return 32'h40;
            default: return 32'(4 * k);
        endcase
    endfunction

    function automatic logic [31:0] bp_of(input int kind, input int k);
        case (kind)
            1:       return 32'h10;
            3:       return (k == 4) ? 32'h10 : 32'hFF;
            4:       return 32'h40;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic launch(input logic [1:0] m);
        mode  = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("launch_st1", 32'(state), 32'd1);
        chk("launch_cnt_clr", cycle_cnt, 32'd0);
        chk("launch_flags_clr", {30'd0, halted, timeout}, 32'd0);
        tick();
        chk("hold_st", 32'(state), 32'd1);
        chk("hold_rst", 32'(cpu_rst), 32'd1);
        tick();
        chk("run_st", 32'(state), (m == 2'd1) ? 32'd3 : 32'd2);
        chk("run_rst", 32'(cpu_rst), 32'd0);
    endtask

    // Drive the core PC on enabled cycles until HALT, then score the result
    task automatic run_pc(input int kind, input int budget);
        int   k = 0;
        bit   done = 0;
        bit   was_en;
        exp_t e;
        for (int c = 0; c < budget && !done; c++) begin
            was_en = cpu_en;
            if (cpu_en) begin
                pc      = pc_of(kind, k);
                bp_addr = bp_of(kind, k);
            end
            start = (kind == 2 && k == 100 && cpu_en);
            tick();
            start = 1'b0;
            if (was_en) k++;
            if (state == 3'd5) done = 1;
        end
        e = sb.pop_front();
        if (!done) begin
            chk("halt_wait", 32'd0, 32'd1);
        end else begin
            chk("halted", 32'(halted), 32'(e.h));
            chk("timeout", 32'(timeout), 32'(e.t));
            chk("halt_pc", halt_pc, e.hpc);
            chk("halt_cnt", cycle_cnt, e.cnt);
            chk("halt_en", 32'(cpu_en), 32'd0);
        end
    endtask

    initial begin
        int nexec;
        pc_rst = 1'b1; start = 1'b0; step_req = 1'b0; mode = 2'd0;
        bp_addr = 32'hFFFF_FFFF; pc = 32'd0;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("rst_cpu_en", 32'(cpu_en), 32'd0);
        chk("rst_cnt", cycle_cnt, 32'd0);
        chk("rst_flags", {30'd0, halted, timeout}, 32'd0);
        chk("rst_hpc", halt_pc, 32'd0);
        tick(); tick();
        pc_rst = 1'b0;
        tick();

        // free-run into a self-loop at 0x20
        sb.push_back('{1'b1, 1'b0, 32'h20, 32'd12});
        launch(2'd0);
        run_pc(0, 100);
        tick(); tick(); tick();
        chk("hold_cnt", cycle_cnt, 32'd12);
        chk("hold_state", 32'(state), 32'd5);
        chk("hold_cpu_rst", 32'(cpu_rst), 32'd0);

        // breakpoint at 0x10
        sb.push_back('{1'b1, 1'b0, 32'h10, 32'd5});
        launch(2'd2);
        run_pc(1, 100);

        // breakpoint coinciding with a stall
        sb.push_back('{1'b1, 1'b0, 32'h10, 32'd5});
        launch(2'd2);
        run_pc(3, 100);

        // breakpoint on the very first enabled cycle
        sb.push_back('{1'b1, 1'b0, 32'h40, 32'd1});
        bp_addr = 32'h40;
        launch(2'd2);
        run_pc(4, 20);

        // single step: held request then three pulses
        launch(2'd1);
        nexec = 0;
        for (int c = 0; c < 30; c++) begin
            step_req = (c < 5) || (c == 6) || (c == 8) || (c == 10);
            if (cpu_en) pc = 32'h100 + 32'(4 * nexec);
            tick();
            if (state == 3'd4) nexec++;
        end
        step_req = 1'b0;
        chk("step_execs", 32'(nexec), 32'd4);
        chk("step_cnt", cycle_cnt, 32'd4);
        chk("step_state", 32'(state), 32'd3);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("step_start_ign", 32'(state), 32'd3);

        // abort mid-run with pc_rst, then relaunch
        pc_rst = 1'b1;
        tick();
        pc_rst = 1'b0;
        launch(2'd3);
        for (int c = 0; c < 50; c++) begin
            pc = 32'h200 + 32'(4 * c);
            tick();
        end
        chk("pre_abort_cnt", cycle_cnt, 32'd50);
        pc_rst = 1'b1;
        #1;
        chk("abort_cpu_rst", 32'(cpu_rst), 32'd1);
        chk("abort_cpu_en", 32'(cpu_en), 32'd0);
        chk("abort_cnt", cycle_cnt, 32'd0);
        chk("abort_state", 32'(state), 32'd0);
        tick();
        pc_rst = 1'b0;
        sb.push_back('{1'b1, 1'b0, 32'h20, 32'd12});
        launch(2'd0);
        run_pc(0, 100);

        // cycle-budget timeout; a start mid-run must be ignored
        sb.push_back('{1'b0, 1'b1, 32'(4 * 9999), 32'd10000});
        launch(2'd0);
        run_pc(2, 10100);
        tick(); tick();
        chk("to_en_after", 32'(cpu_en), 32'd0);
        chk("to_cnt_after", cycle_cnt, 32'd10000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
- Synthesizable run controller for the mips core; replaces fixed-delay reset and fixed-time stop sequencing with a parametrised controller.
- Sequences the core reset and gates core execution through a clock enable.
- Supports free-run, single-step and run-to-breakpoint modes.
- Counts executed cycles and detects halt: self-loop PC, breakpoint hit, or cycle timeout.
- Sits between board/bench stimulus and the `mips` top, observing the core's PC.

Parameters:
- PC_W, 32, width of the observed PC and breakpoint address.
- CNT_W, 32, width of the cycle counter.
- RST_CYC, 2, number of cycles `cpu_rst` is held high after `start`; must be >= 1.
- STALL_CYC, 4, consecutive enabled cycles with an unchanged PC that declare a halt; must be >= 2.
- MAX_CYC, 10000, enabled-cycle budget before a timeout halt; must be < 2^CNT_W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- pc_rst  in  1  asynchronous, active-high reset of this controller.
- start  in  1  level-sampled launch request; honoured only in IDLE or HALT.
- mode  in  2  run mode: 0 free-run, 1 single-step, 2 run-to-breakpoint, 3 reserved (treated as 0).
- step_req  in  1  step request; a rising edge (detected internally) grants exactly one step.
- bp_addr  in  PC_W  breakpoint address, used in mode 2.
- pc  in  PC_W  current PC of the core.
- cpu_rst  out  1  reset driven into the core.
- cpu_en  out  1  clock enable for the core.
- cycle_cnt  out  CNT_W  number of enabled cycles since the last launch.
- state  out  3  current FSM state encoding.
- halted  out  1  set when a PC-based halt occurs (stall or breakpoint).
- timeout  out  1  set when a timeout halt occurs.
- halt_pc  out  PC_W  PC captured at the halt.

Behaviour:
- Reset values (while `pc_rst` is high, asynchronously): state=IDLE, cpu_rst=1, cpu_en=0, cycle_cnt=0, halted=0, timeout=0, halt_pc=0; the internal hold counter, stall counter, prev_pc and step edge register are all 0.
- State encodings: IDLE=0, RST_HOLD=1, RUN=2, STEP_WAIT=3, STEP_EXEC=4, HALT=5.
- Output decode is Moore:
  - cpu_rst = (state==IDLE || state==RST_HOLD).
  - cpu_en = (state==RUN || state==STEP_EXEC).
- IDLE/HALT with start=1 -> RST_HOLD. On that edge: cycle_cnt, halted, timeout, halt_pc, stall counter and prev_pc are cleared, and the hold counter is loaded with 0.
- RST_HOLD:
  - The hold counter increments each cycle.
  - After exactly RST_CYC cycles in RST_HOLD, go to STEP_WAIT if mode==1, else RUN.
  - `mode` is sampled on that exit edge only.
- start while in RUN, STEP_WAIT or STEP_EXEC is ignored.
- STEP_WAIT: a step_req rising edge -> STEP_EXEC. STEP_EXEC always returns to STEP_WAIT after 1 cycle unless a halt fires. A held-high step_req yields one step only.
- On every cpu_en cycle:
  - cycle_cnt increments, saturating at 2^CNT_W-1.
  - prev_pc <= pc.
  - stall counter increments if pc==prev_pc, else it is cleared to 0.
- Halt conditions, evaluated only on cpu_en cycles, in priority order:
  1. Breakpoint: mode==2 and pc==bp_addr.
  2. Stall: stall counter == STALL_CYC-2 and pc==prev_pc, i.e. the same PC seen on STALL_CYC consecutive enabled cycles.
  3. Timeout: the count after this increment equals MAX_CYC.
- On a halt: next state=HALT, halt_pc<=pc. halted<=1 for conditions 1 and 2; timeout<=1 for condition 3 only. Exactly one of the two flags is set.
- Breakpoint at the very first enabled cycle (pc==bp_addr right out of reset) halts immediately with cycle_cnt=1.
- HALT: cpu_en=0 and cpu_rst=0, so core state is frozen for inspection. All flags and cycle_cnt hold until the next start.
- pc_rst asserted mid-run aborts immediately to reset values. The core sees cpu_rst=1 the same instant.

Decomposition:
- Shared package `mips_run_pkg`: state encoding constants (IDLE..HALT) and mode constants (MODE_FREE=0, MODE_STEP=1, MODE_BP=2).
- One natural sub-module, `halt_detect`: holds prev_pc, the stall counter and the three comparators, and outputs halt_bp, halt_stall and halt_to. The FSM, hold counter, step edge detect and cycle counter stay in the top.

Test Plan:
- Reset then start=1 for 1 cycle, mode=0 -> cpu_rst high for exactly 2 cycles after the start edge, then cpu_en=1; state goes 0->1->2.
- Mode 0, pc increments by 4 from 0, then sticks at 0x20 -> HALT on the 4th consecutive 0x20 sample; halted=1, timeout=0, halt_pc=0x20, cycle_cnt=12.
- Mode 2, bp_addr=0x10, pc=0,4,8,0xC,0x10 -> HALT with halted=1, halt_pc=0x10, cycle_cnt=5; the same cycle also meets the stall condition (forced) -> still a breakpoint halt, timeout=0.
- Mode 1, step_req held high for 5 cycles, then 3 separate 1-cycle pulses -> exactly 4 STEP_EXEC cycles, cycle_cnt=4, state returns to 3.
- Mode 0 with MAX_CYC=10000 and an ever-incrementing pc -> timeout=1, halted=0, cycle_cnt=10000, cpu_en=0 thereafter.
- pc_rst pulsed in RUN at cycle 50 -> immediate cpu_rst=1, cpu_en=0, cycle_cnt=0, state=0; a subsequent start relaunches normally.
